// File: rtl/usb_msc_pkg.sv
// rtl/usb_msc_pkg.sv - shared constants and types for the MSC command path
package usb_msc_pkg;

  localparam logic [31:0] CBW_SIGNATURE = 32'h43425355;
  localparam int          CBW_WORDS     = 8;

  localparam logic [2:0] ERR_NONE  = 3'd0;
  localparam logic [2:0] ERR_SIG   = 3'd1;
  localparam logic [2:0] ERR_LUN   = 3'd2;
  localparam logic [2:0] ERR_CBLEN = 3'd3;
  localparam logic [2:0] ERR_GAP   = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_PRESENT,
    ST_DRAIN
  } cbw_state_e;

  // Byte-enable mask keeping CDB bytes below cb_len; 16 selects all bytes.
  function automatic logic [127:0] cdb_mask(input logic [4:0] cb_len);
    logic [127:0] m;
    m = '0;
    for (int i = 0; i < 16; i++) begin
      if (5'(i) < cb_len) m[i*8 +: 8] = 8'hFF;
    end
    return m;
  endfunction

endpackage

// File: rtl/usb_msc_cbw_parser_if.sv
// rtl/usb_msc_cbw_parser_if.sv - CBW word stream in, decoded command out
interface usb_msc_cbw_parser_if;
  logic [31:0]  in_data;
  logic         in_valid;
  logic         in_ready;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [31:0]  cmd_tag;
  logic [31:0]  cmd_xfer_len;
  logic         cmd_dir_in;
  logic [3:0]   cmd_lun;
  logic [4:0]   cmd_cb_len;
  logic [127:0] cmd_cdb;

  modport master (
    output in_data, in_valid, cmd_ready,
    input  in_ready, cmd_valid, cmd_tag, cmd_xfer_len, cmd_dir_in,
           cmd_lun, cmd_cb_len, cmd_cdb
  );

  modport slave (
    input  in_data, in_valid, cmd_ready,
    output in_ready, cmd_valid, cmd_tag, cmd_xfer_len, cmd_dir_in,
           cmd_lun, cmd_cb_len, cmd_cdb
  );
endinterface

// File: rtl/msc_gap_timer.sv
// rtl/msc_gap_timer.sv - loadable 16-bit idle counter with timeout strobe
module msc_gap_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic [15:0] load_value_i,
  input  logic        en_i,
  input  logic [15:0] limit_i,
  output logic        timeout_o
);

  logic [15:0] count_q, count_d;

  // Saturates so a caller that ignores the strobe never sees a wrap.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_value_i;
    end else if (en_i && (count_q != 16'hFFFF)) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign timeout_o = en_i && (count_q == limit_i);

endmodule

// File: rtl/usb_msc_cbw_parser.sv
// rtl/usb_msc_cbw_parser.sv - assembles and validates the 31-byte CBW
module usb_msc_cbw_parser #(
  parameter logic [31:0] CBW_SIGNATURE = usb_msc_pkg::CBW_SIGNATURE,
  parameter logic [3:0]  MAX_LUN       = 4'd0,
  parameter logic [15:0] GAP_TIMEOUT   = 16'd1024
) (
  input  logic                        clk,
  input  logic                        rst,
  usb_msc_cbw_parser_if.slave         bus,
  output logic                        err_valid,
  output logic [2:0]                  err_code,
  output logic                        transfer_active,
  output logic                        transfer_done,
  output logic [15:0]                 cbw_ok_count,
  output logic [15:0]                 cbw_err_count
);
  import usb_msc_pkg::*;

  localparam logic [2:0] LAST_WORD = 3'(CBW_WORDS - 1);

  cbw_state_e   state_q, state_d;
  logic [2:0]   wcnt_q, wcnt_d;
  logic [31:0]  tag_q, tag_d;
  logic [31:0]  len_q, len_d;
  logic         dir_q, dir_d;
  logic [7:0]   lun_q, lun_d;
  logic [7:0]   cblen_q, cblen_d;
  logic [127:0] cdb_q, cdb_d;
  logic         err_q, err_d;
  logic [2:0]   code_q, code_d;
  logic         done_q, done_d;
  logic         active_q, active_d;
  logic [15:0]  ok_q, ok_d;
  logic [15:0]  errc_q, errc_d;

  logic accept;
  logic lun_bad;
  logic cblen_bad;
  logic gap_load;
  logic gap_en;
  logic gap_timeout;

  assign bus.in_ready = (state_q != ST_PRESENT);
  assign accept       = bus.in_valid && bus.in_ready;

  // Validation reads the W3 fields captured earlier, so it is ready on W7.
  assign lun_bad   = (lun_q[7:4] != 4'd0) || (lun_q[3:0] > MAX_LUN);
  assign cblen_bad = (cblen_q == 8'd0) || (cblen_q > 8'd16);

  assign gap_load = accept || (state_d != state_q);
  assign gap_en   = (state_q == ST_COLLECT) || (state_q == ST_DRAIN);

  msc_gap_timer u_gap_timer (
    .clk          (clk),
    .rst          (rst),
    .load_i       (gap_load),
    .load_value_i (16'd0),
    .en_i         (gap_en),
    .limit_i      (GAP_TIMEOUT),
    .timeout_o    (gap_timeout)
  );

  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    tag_d    = tag_q;
    len_d    = len_q;
    dir_d    = dir_q;
    lun_d    = lun_q;
    cblen_d  = cblen_q;
    cdb_d    = cdb_q;
    err_d    = 1'b0;
    code_d   = code_q;
    done_d   = 1'b0;
    active_d = active_q;
    ok_d     = ok_q;
    errc_d   = errc_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (bus.in_data == CBW_SIGNATURE) begin
            state_d  = ST_COLLECT;
            wcnt_d   = 3'd1;
            active_d = 1'b1;
          end else begin
            err_d   = 1'b1;
            code_d  = ERR_SIG;
            state_d = ST_DRAIN;
          end
        end
      end
      ST_COLLECT: begin
        if (accept) begin
          wcnt_d = wcnt_q + 3'd1;
          case (wcnt_q)
            3'd1: tag_d = bus.in_data;
            3'd2: len_d = bus.in_data;
            3'd3: begin
              dir_d         = bus.in_data[7];
              lun_d         = bus.in_data[15:8];
              cblen_d       = bus.in_data[23:16];
              cdb_d[7:0]    = bus.in_data[31:24];
            end
            3'd4: cdb_d[39:8]    = bus.in_data;
            3'd5: cdb_d[71:40]   = bus.in_data;
            3'd6: cdb_d[103:72]  = bus.in_data;
            3'd7: cdb_d[127:104] = bus.in_data[23:0];
            default: ;
          endcase
          if (wcnt_q == LAST_WORD) begin
            if (lun_bad) begin
              err_d   = 1'b1;
              code_d  = ERR_LUN;
              state_d = ST_DRAIN;
            end else if (cblen_bad) begin
              err_d   = 1'b1;
              code_d  = ERR_CBLEN;
              state_d = ST_DRAIN;
            end else begin
              state_d = ST_PRESENT;
            end
          end
        end else if (gap_timeout) begin
          err_d   = 1'b1;
          code_d  = ERR_GAP;
          state_d = ST_IDLE;
        end
      end
      ST_PRESENT: begin
        if (bus.cmd_ready) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          ok_d    = ok_q + 16'd1;
        end
      end
      ST_DRAIN: begin
        if (!accept && gap_timeout) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (err_d) begin
      done_d = 1'b1;
      errc_d = errc_q + 16'd1;
    end
    if (done_d) active_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      wcnt_q   <= '0;
      tag_q    <= '0;
      len_q    <= '0;
      dir_q    <= 1'b0;
      lun_q    <= '0;
      cblen_q  <= '0;
      cdb_q    <= '0;
      err_q    <= 1'b0;
      code_q   <= ERR_NONE;
      done_q   <= 1'b0;
      active_q <= 1'b0;
      ok_q     <= '0;
      errc_q   <= '0;
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      tag_q    <= tag_d;
      len_q    <= len_d;
      dir_q    <= dir_d;
      lun_q    <= lun_d;
      cblen_q  <= cblen_d;
      cdb_q    <= cdb_d;
      err_q    <= err_d;
      code_q   <= code_d;
      done_q   <= done_d;
      active_q <= active_d;
      ok_q     <= ok_d;
      errc_q   <= errc_d;
    end
  end

  assign bus.cmd_valid    = (state_q == ST_PRESENT);
  assign bus.cmd_tag      = tag_q;
  assign bus.cmd_xfer_len = len_q;
  assign bus.cmd_dir_in   = dir_q;
  assign bus.cmd_lun      = lun_q[3:0];
  assign bus.cmd_cb_len   = cblen_q[4:0];
  assign bus.cmd_cdb      = cdb_q & cdb_mask(cblen_q[4:0]);

  assign err_valid       = err_q;
  assign err_code        = code_q;
  assign transfer_active = active_q;
  assign transfer_done   = done_q;
  assign cbw_ok_count    = ok_q;
  assign cbw_err_count   = errc_q;

endmodule

// File: tb/tb_usb_msc_cbw_parser.sv
// tb/tb_usb_msc_cbw_parser.sv - directed self-checking bench for the CBW parser
module tb_usb_msc_cbw_parser;

  localparam logic [31:0]  SIG        = 32'h43425355;
  localparam logic [127:0] CDB_RD10_IN = 128'hAAAAAAAAAAAA_0001_0000_1000_0000_0028;
  localparam logic [127:0] CDB_RD10    = 128'h000000000000_0001_0000_1000_0000_0028;
  localparam logic [127:0] CDB_FULL    = 128'hF0E1D2C3B4A59687_7869_5A4B_3C2D_1E0F;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  usb_msc_cbw_parser_if bus();

  logic        err_valid;
  logic [2:0]  err_code;
  logic        transfer_active;
  logic        transfer_done;
  logic [15:0] ok_cnt;
  logic [15:0] err_cnt;

  usb_msc_cbw_parser dut (
    .clk             (clk),
    .rst             (rst),
    .bus             (bus),
    .err_valid       (err_valid),
    .err_code        (err_code),
    .transfer_active (transfer_active),
    .transfer_done   (transfer_done),
    .cbw_ok_count    (ok_cnt),
    .cbw_err_count   (err_cnt)
  );

  int total = 0;
  int bad   = 0;
  int n_err = 0;
  int n_acc = 0;
  int n_cv  = 0;
  int exp_err = 0;
  int e0, a0, c0;
  logic [31:0] w [8];

  always @(negedge clk) begin
    if (!rst) begin
      if (err_valid) n_err++;
      if (bus.in_valid && bus.in_ready) n_acc++;
      if (bus.cmd_valid) n_cv++;
    end
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic make_cbw(input logic [31:0] sig, input logic [31:0] tag, input logic [31:0] len,
                          input logic [7:0] flags, input logic [7:0] lun, input logic [7:0] cblen,
                          input logic [127:0] cdb);
    w[0] = sig;
    w[1] = tag;
    w[2] = len;
    w[3] = {cdb[7:0], cblen, lun, flags};
    w[4] = cdb[39:8];
    w[5] = cdb[71:40];
    w[6] = cdb[103:72];
    w[7] = {8'hA5, cdb[127:104]};
  endtask

  task automatic send_words(input int n);
    for (int i = 0; i < n; i++) begin
      bus.in_data  = w[i];
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic run_bad(input string tag, input logic [7:0] lun, input logic [7:0] cblen,
                         input logic [2:0] code);
    make_cbw(SIG, 32'h00000001, 32'h0, 8'h00, lun, cblen, CDB_FULL);
    e0 = n_err;
    c0 = n_cv;
    send_words(8);
    @(negedge clk);
    exp_err++;
    check({tag, "_code"}, err_code, code);
    check({tag, "_errv"}, err_valid, 1'b1);
    check({tag, "_done"}, transfer_done, 1'b1);
    check({tag, "_errcnt"}, err_cnt, exp_err);
    idle(1100);
    check({tag, "_pulses"}, n_err - e0, 1);
    check({tag, "_nocmd"}, n_cv - c0, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.cmd_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1'b1);
    check("rst_cmd_valid", bus.cmd_valid, 1'b0);
    check("rst_tag", bus.cmd_tag, 32'h0);
    check("rst_cdb", bus.cmd_cdb, 128'h0);
    check("rst_err_code", err_code, 3'd0);
    check("rst_counts", {ok_cnt, err_cnt}, 32'h0);
    check("rst_flags", {err_valid, transfer_active, transfer_done}, 3'b000);
    @(posedge clk); #1;

    // valid READ(10); CDB bytes past cb_len carry junk that must be masked
    make_cbw(SIG, 32'hDEADBEEF, 32'h200, 8'h80, 8'h00, 8'd10, CDB_RD10_IN);
    send_words(8);
    @(negedge clk);
    check("rd10_valid", bus.cmd_valid, 1'b1);
    check("rd10_tag", bus.cmd_tag, 32'hDEADBEEF);
    check("rd10_len", bus.cmd_xfer_len, 32'h200);
    check("rd10_dir", bus.cmd_dir_in, 1'b1);
    check("rd10_lun", bus.cmd_lun, 4'd0);
    check("rd10_cblen", bus.cmd_cb_len, 5'd10);
    check("rd10_cdb", bus.cmd_cdb, CDB_RD10);
    check("rd10_active", transfer_active, 1'b1);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check("hold_in_ready", bus.in_ready, 1'b0);
      check("hold_fields", {bus.cmd_valid, bus.cmd_tag, bus.cmd_cdb[79:0]},
            {1'b1, 32'hDEADBEEF, CDB_RD10[79:0]});
    end
    @(posedge clk); #1 bus.cmd_ready = 1'b1;
    @(posedge clk); #1 bus.cmd_ready = 1'b0;
    @(negedge clk);
    check("rd10_done", transfer_done, 1'b1);
    check("rd10_ok", ok_cnt, 16'd1);
    check("rd10_released", {bus.cmd_valid, bus.in_ready, transfer_active}, 3'b010);
    @(negedge clk);
    check("rd10_done_once", transfer_done, 1'b0);
    @(posedge clk); #1;

    // second CBW: full 16-byte CDB, zero length, ready held high early
    bus.cmd_ready = 1'b1;
    make_cbw(SIG, 32'h12345678, 32'h0, 8'h00, 8'h00, 8'd16, CDB_FULL);
    send_words(8);
    @(negedge clk);
    check("b2b_valid", bus.cmd_valid, 1'b1);
    check("b2b_ok_early", ok_cnt, 16'd1);
    check("b2b_tag", bus.cmd_tag, 32'h12345678);
    check("b2b_len", bus.cmd_xfer_len, 32'h0);
    check("b2b_dir", bus.cmd_dir_in, 1'b0);
    check("b2b_cblen", bus.cmd_cb_len, 5'd16);
    check("b2b_cdb", bus.cmd_cdb, CDB_FULL);
    @(posedge clk); #1 bus.cmd_ready = 1'b0;
    @(negedge clk);
    check("b2b_ok", ok_cnt, 16'd2);
    check("b2b_done", transfer_done, 1'b1);
    @(posedge clk); #1;

    // bad signature followed by the rest of a CBW
    make_cbw(32'h46525751, 32'h1, 32'h0, 8'h00, 8'h00, 8'd6, CDB_FULL);
    e0 = n_err; a0 = n_acc; c0 = n_cv;
    send_words(8);
    @(negedge clk);
    exp_err++;
    check("sig_code", err_code, 3'd1);
    check("sig_errcnt", err_cnt, exp_err);
    check("sig_accepted", n_acc - a0, 8);
    idle(1100);
    check("sig_pulses", n_err - e0, 1);
    check("sig_nocmd", n_cv - c0, 0);
    check("sig_inactive", transfer_active, 1'b0);

    run_bad("cblen17", 8'h00, 8'd17, 3'd3);
    run_bad("cblen0", 8'h00, 8'd0, 3'd3);
    run_bad("lun1", 8'h01, 8'd6, 3'd2);
    run_bad("lun10", 8'h10, 8'd6, 3'd2);
    run_bad("prio", 8'h01, 8'd0, 3'd2);

    // stall after W3 until the gap timer fires
    make_cbw(SIG, 32'hCAFEF00D, 32'h40, 8'h80, 8'h00, 8'd6, CDB_FULL);
    e0 = n_err;
    send_words(4);
    idle(1020);
    check("gap_not_yet", n_err - e0, 0);
    check("gap_active", transfer_active, 1'b1);
    idle(80);
    exp_err++;
    check("gap_code", err_code, 3'd4);
    check("gap_pulses", n_err - e0, 1);
    check("gap_errcnt", err_cnt, exp_err);
    check("gap_inactive", transfer_active, 1'b0);
    make_cbw(SIG, 32'h0BADF00D, 32'h1000, 8'h00, 8'h00, 8'd6, CDB_FULL);
    send_words(8);
    @(negedge clk);
    check("after_gap_valid", bus.cmd_valid, 1'b1);
    check("after_gap_tag", bus.cmd_tag, 32'h0BADF00D);
    check("after_gap_cdb", bus.cmd_cdb, {80'h0, CDB_FULL[47:0]});
    @(posedge clk); #1 bus.cmd_ready = 1'b1;
    @(posedge clk); #1 bus.cmd_ready = 1'b0;
    @(negedge clk);
    check("after_gap_ok", ok_cnt, 16'd3);
    @(posedge clk); #1;

    // reset in the middle of a CBW
    make_cbw(SIG, 32'h55AA55AA, 32'h8, 8'h80, 8'h00, 8'd6, CDB_FULL);
    e0 = n_err;
    send_words(5);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("mid_rst_in_ready", bus.in_ready, 1'b1);
    check("mid_rst_counts", {ok_cnt, err_cnt}, 32'h0);
    check("mid_rst_flags", {bus.cmd_valid, err_valid, transfer_active, transfer_done}, 4'b0000);
    check("mid_rst_code", err_code, 3'd0);
    check("mid_rst_tag", bus.cmd_tag, 32'h0);
    idle(20);
    check("mid_rst_no_err", n_err - e0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
